register_file: RTL
==================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: register width in bits.
REQ-002 SHALL have parameter REG_NUM, default 32: number of architectural registers.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 32: PC width in bits.
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_rf_wr_en  input  1  write request from the writeback stage.
REQ-007 SHALL have port i_rf_wr_addr  input  $clog2(REG_NUM)  write register index.
REQ-008 SHALL have port i_rf_wr_data  input  DATA_WIDTH  write data.
REQ-009 SHALL have port i_pc  input  ADDRESS_WIDTH  PC of the instruction in writeback.
REQ-010 SHALL have port i_ecall  input  1  ecall retiring this cycle.
REQ-011 SHALL have ports i_rs1_addr and i_rs2_addr  input  $clog2(REG_NUM) each  read indices.
REQ-012 SHALL have ports o_rs1_data and o_rs2_data  output  DATA_WIDTH each  read data.
REQ-013 SHALL have port o_halt  output  1  core halted by ecall.
REQ-014 SHALL have port o_ecall_pc  output  ADDRESS_WIDTH  PC of the halting ecall.
REQ-015 SHALL have port o_wr_count  output  32  count of committed register writes.

Function
REQ-016 SHALL commit a write at the rising edge when i_rf_wr_en=1, i_rf_wr_addr!=0, o_halt=0 and i_rst=0.
REQ-017 SHALL hardwire register 0: writes to index 0 are discarded; reads of index 0 return 0.
REQ-018 SHALL provide combinational reads with zero-cycle latency on both ports, independent of each other.
REQ-019 SHALL bypass write to read: if a write qualifies per REQ-016 and its address equals a read address, that port returns i_rf_wr_data in the same cycle.
REQ-020 SHALL return the same bypassed value on both ports when rs1 and rs2 both match the write address.
REQ-021 SHALL implement a two-state FSM, RUN and HALTED; reset enters RUN.
REQ-022 SHALL move RUN->HALTED at the edge where i_ecall=1; o_halt rises the following cycle; HALTED is left only by reset.
REQ-023 SHALL capture i_pc into o_ecall_pc on the RUN->HALTED transition and hold it while in HALTED.
REQ-024 SHALL commit a write that is presented in the same cycle as i_ecall; writes presented in HALTED are dropped.
REQ-025 SHALL ignore i_ecall while in HALTED (o_ecall_pc unchanged).
REQ-026 SHALL disable the bypass of REQ-019 while in HALTED; reads return stored contents.
REQ-027 SHALL increment o_wr_count by 1 per committed write (REQ-016) and wrap modulo 2^32.
REQ-028 SHALL keep reads functional in HALTED for debug inspection.

Reset
REQ-029 SHALL, when i_rst=1 at an edge, clear all registers to 0, set FSM=RUN, o_halt=0, o_ecall_pc=0 and o_wr_count=0.
REQ-030 SHALL give reset priority over a simultaneous write or ecall; neither takes effect in that cycle.
REQ-031 SHALL keep the read ports combinational during reset; they return pre-reset contents until the reset edge.

Structure
REQ-032 SHALL place the FSM state enum (RUN, HALTED) and the x0 index constant in the shared core package.
REQ-033 SHALL use no sub-modules; storage, bypass, FSM and counter reside in register_file.

Verification
REQ-034 SHALL cover write then read: write x5=0xDEADBEEF, next cycle rs1=5 -> o_rs1_data=0xDEADBEEF, o_wr_count=1.
REQ-035 SHALL cover x0: write x0=0x12345678 -> rs1=0 returns 0 in the same and next cycles; o_wr_count unchanged.
REQ-036 SHALL cover bypass: write x7=0xA5A5A5A5 with rs1=rs2=7 in the same cycle -> both ports 0xA5A5A5A5 that cycle.
REQ-037 SHALL cover ecall: i_ecall=1, i_pc=0x00000040, with write x3=0x11 -> next cycle o_halt=1, o_ecall_pc=0x40, x3=0x11; a later write x3=0x22 is dropped, x3 reads 0x11.
REQ-038 SHALL cover reset mid-operation: from HALTED with x3=0x11, assert i_rst with write x4=0x99 -> o_halt=0, o_ecall_pc=0, x3=0, x4=0, o_wr_count=0.
REQ-039 SHALL cover counter wrap: preload o_wr_count to 0xFFFFFFFF, commit one write -> o_wr_count=0.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared core definitions for the register file:
// halt FSM states and the hardwired-zero register index.
package register_file_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } rf_state_e;

  localparam int unsigned X0 = 0;

endpackage

// File: rtl/register_file.sv
// Architectural register file with write-to-read bypass,
// ecall halt FSM and a committed-write counter.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM       = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_rf_wr_en,
  input  logic [$clog2(REG_NUM)-1:0] i_rf_wr_addr,
  input  logic [DATA_WIDTH-1:0]      i_rf_wr_data,
  input  logic [ADDRESS_WIDTH-1:0]   i_pc,
  input  logic                       i_ecall,
  input  logic [$clog2(REG_NUM)-1:0] i_rs1_addr,
  input  logic [$clog2(REG_NUM)-1:0] i_rs2_addr,
  output logic [DATA_WIDTH-1:0]      o_rs1_data,
  output logic [DATA_WIDTH-1:0]      o_rs2_data,
  output logic                       o_halt,
  output logic [ADDRESS_WIDTH-1:0]   o_ecall_pc,
  output logic [31:0]                o_wr_count
);

  localparam int IDX_W = $clog2(REG_NUM);
  localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(X0);

  logic [DATA_WIDTH-1:0]    regs [REG_NUM];
  rf_state_e                state;
  logic [ADDRESS_WIDTH-1:0] ecall_pc;
  logic [31:0]              wr_count;
  logic                     commit;

  assign commit = i_rf_wr_en
                & (i_rf_wr_addr != ZERO_IDX)
                & (state == RUN)
                & ~i_rst;

  // commit already excludes x0, halted and reset
  always_comb begin
    o_rs1_data = '0;
    if (commit && i_rs1_addr == i_rf_wr_addr)
      o_rs1_data = i_rf_wr_data;
    else if (i_rs1_addr != ZERO_IDX)
      o_rs1_data = regs[i_rs1_addr];
  end

  always_comb begin
    o_rs2_data = '0;
    if (commit && i_rs2_addr == i_rf_wr_addr)
      o_rs2_data = i_rf_wr_data;
    else if (i_rs2_addr != ZERO_IDX)
      o_rs2_data = regs[i_rs2_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < REG_NUM; i++)
        regs[i] <= '0;
    end else if (commit) begin
      regs[i_rf_wr_addr] <= i_rf_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= RUN;
      ecall_pc <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (i_ecall) begin
            state    <= HALTED;
            ecall_pc <= i_pc;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      wr_count <= '0;
    else if (commit)
      wr_count <= wr_count + 32'd1;
  end

  assign o_halt     = (state == HALTED);
  assign o_ecall_pc = ecall_pc;
  assign o_wr_count = wr_count;

endmodule
